// File: rtl/btb_set_assoc.sv
// Set-associative BTB with per-set tree pseudo-LRU; lookup is combinational, writes/flush land next edge.
// No backpressure: an update is accepted every cycle, and a flush in that cycle discards it.
module btb_set_assoc #(
    parameter  int NUM_SETS = 16,
    parameter  int NUM_WAYS = 4,
    localparam int IDX_W    = $clog2(NUM_SETS),
    localparam int WAY_W    = $clog2(NUM_WAYS),
    localparam int TAG_W    = 30 - IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lk_valid,
    input  logic [31:0]      lk_pc,
    output logic             pred_hit,
    output logic [31:0]      pred_target,
    output logic [WAY_W-1:0] pred_way,
    input  logic             upd_valid,
    input  logic [31:0]      upd_pc,
    input  logic [31:0]      upd_target,
    input  logic             upd_taken,
    input  logic             flush
);

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [31:0]      target;
    } entry_t;

    logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
    logic [NUM_WAYS-2:0] plru_q  [NUM_SETS];
    entry_t              ent_q   [NUM_SETS][NUM_WAYS];

    // Point every node on the root-to-leaf path away from the touched way.
    function automatic logic [NUM_WAYS-2:0] plru_touch(input logic [NUM_WAYS-2:0] bits,
                                                       input logic [WAY_W-1:0]    way);
        logic [NUM_WAYS-2:0] r;
        int                  node;
        r    = bits;
        node = 0;
        for (int lvl = WAY_W - 1; lvl >= 0; lvl--) begin
            r[node] = ~way[lvl];
            node    = 2 * node + 1 + int'(way[lvl]);
        end
        return r;
    endfunction

    function automatic logic [WAY_W-1:0] plru_victim(input logic [NUM_WAYS-2:0] bits);
        logic [WAY_W-1:0] w;
        int               node;
        w    = '0;
        node = 0;
        for (int lvl = WAY_W - 1; lvl >= 0; lvl--) begin
            w[lvl] = bits[node];
            node   = 2 * node + 1 + int'(bits[node]);
        end
        return w;
    endfunction

    logic [IDX_W-1:0] lk_idx, upd_idx;
    logic [TAG_W-1:0] lk_tag, upd_tag;

    assign lk_idx  = lk_pc[IDX_W+1:2];
    assign lk_tag  = lk_pc[31:IDX_W+2];
    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_tag = upd_pc[31:IDX_W+2];

    always_comb begin
        pred_hit    = 1'b0;
        pred_way    = '0;
        pred_target = lk_pc + 32'd4;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid_q[lk_idx][w] && ent_q[lk_idx][w].tag == lk_tag) begin
                pred_hit    = 1'b1;
                pred_way    = WAY_W'(w);
                pred_target = ent_q[lk_idx][w].target;
            end
        end
    end

    logic             upd_we, upd_hit, free_found, lk_touch;
    logic [WAY_W-1:0] upd_hit_way, free_way, wr_way;
    logic [NUM_WAYS-2:0] upd_plru_base;

    assign upd_we   = upd_valid & upd_taken;
    assign lk_touch = lk_valid & pred_hit;

    // Scan downwards so the lowest-numbered free way is the one left selected.
    always_comb begin
        upd_hit     = 1'b0;
        upd_hit_way = '0;
        free_found  = 1'b0;
        free_way    = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (valid_q[upd_idx][w] && ent_q[upd_idx][w].tag == upd_tag) begin
                upd_hit     = 1'b1;
                upd_hit_way = WAY_W'(w);
            end
            if (!valid_q[upd_idx][w]) begin
                free_found = 1'b1;
                free_way   = WAY_W'(w);
            end
        end
    end

    assign wr_way = upd_hit    ? upd_hit_way :
                    free_found ? free_way    : plru_victim(plru_q[upd_idx]);

    // Same-set lookup touch is folded in first so the update touch wins on shared nodes.
    assign upd_plru_base = (lk_touch && lk_idx == upd_idx) ? plru_touch(plru_q[lk_idx], pred_way)
                                                           : plru_q[upd_idx];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            if (lk_touch) begin
                plru_q[lk_idx] <= plru_touch(plru_q[lk_idx], pred_way);
            end
            if (upd_we) begin
                valid_q[upd_idx][wr_way] <= 1'b1;
                plru_q[upd_idx]          <= plru_touch(upd_plru_base, wr_way);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush && upd_we) begin
            ent_q[upd_idx][wr_way] <= '{tag: upd_tag, target: upd_target};
        end
    end

endmodule

// File: tb/tb_btb_set_assoc.sv
// Directed test-plan steps followed by random traffic, checked against a behavioural BTB model.
module tb_btb_set_assoc;

    logic        clk = 1'b0;
    logic        rst, lk_valid, upd_valid, upd_taken, flush;
    logic [31:0] lk_pc, upd_pc, upd_target;
    logic        pred_hit;
    logic [31:0] pred_target;
    logic [1:0]  pred_way;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    btb_set_assoc dut (
        .clk(clk), .rst(rst), .lk_valid(lk_valid), .lk_pc(lk_pc),
        .pred_hit(pred_hit), .pred_target(pred_target), .pred_way(pred_way),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
        .upd_taken(upd_taken), .flush(flush)
    );

    // Reference model: 16 sets x 4 ways, PLRU tree as a 3-node array per set.
    bit          m_valid [16][4];
    logic [31:0] m_tag   [16][4];
    logic [31:0] m_tgt   [16][4];
    bit          m_plru  [16][3];

    function automatic void m_clear();
        for (int s = 0; s < 16; s++) begin
            for (int w = 0; w < 4; w++) m_valid[s][w] = 0;
            for (int n = 0; n < 3; n++) m_plru[s][n] = 0;
        end
    endfunction

    function automatic void m_lookup(input logic [31:0] pc, output bit hit, output int way,
                                     output logic [31:0] tgt);
        int s = int'((pc >> 2) % 16);
        hit = 0; way = 0; tgt = pc + 32'd4;
        for (int w = 0; w < 4; w++)
            if (m_valid[s][w] && m_tag[s][w] == (pc >> 6)) begin
                hit = 1; way = w; tgt = m_tgt[s][w];
            end
    endfunction

    // Walk leaf-to-root; an odd node number is a left child, which points the parent right.
    function automatic void m_touch(input int s, input int w);
        int n = w + 3;
        while (n > 0) begin
            int p = (n - 1) / 2;
            m_plru[s][p] = (n % 2 == 1);
            n = p;
        end
    endfunction

    function automatic int m_victim(input int s);
        int n = 0;
        while (n < 3) n = 2 * n + 1 + int'(m_plru[s][n]);
        return n - 3;
    endfunction

    function automatic void m_apply();
        bit lhit; int lway; logic [31:0] ltgt;
        int us, uw;
        bit found;
        if (rst || flush) begin
            m_clear();
            return;
        end
        m_lookup(lk_pc, lhit, lway, ltgt);
        us = int'((upd_pc >> 2) % 16);
        found = 0; uw = 0;
        for (int w = 0; w < 4; w++)
            if (!found && m_valid[us][w] && m_tag[us][w] == (upd_pc >> 6)) begin found = 1; uw = w; end
        for (int w = 0; w < 4; w++)
            if (!found && !m_valid[us][w]) begin found = 1; uw = w; end
        if (!found) uw = m_victim(us);
        if (lk_valid && lhit) m_touch(int'((lk_pc >> 2) % 16), lway);
        if (upd_valid && upd_taken) begin
            m_valid[us][uw] = 1;
            m_tag[us][uw]   = upd_pc >> 6;
            m_tgt[us][uw]   = upd_target;
            m_touch(us, uw);
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic idle();
        rst = 0; flush = 0; lk_valid = 0; upd_valid = 0; upd_taken = 0;
        upd_pc = 0; upd_target = 0;
    endtask

    task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input bit taken);
        upd_valid = 1; upd_pc = pc; upd_target = tgt; upd_taken = taken;
    endtask

    // Drive a lookup PC and compare against constants from the test plan.
    task automatic look(input string name, input logic [31:0] pc, input bit hit,
                        input logic [31:0] tgt, input logic [1:0] way);
        lk_pc = pc;
        #1;
        chk({name, "_hit"}, 32'(pred_hit), 32'(hit));
        chk({name, "_tgt"}, pred_target, tgt);
        chk({name, "_way"}, 32'(pred_way), 32'(way));
    endtask

    // Compare outputs with the model, then clock one edge and advance the model.
    task automatic step(input string name);
        bit e_hit; int e_way; logic [31:0] e_tgt;
        #2;
        m_lookup(lk_pc, e_hit, e_way, e_tgt);
        chk({name, "_mhit"}, 32'(pred_hit), 32'(e_hit));
        chk({name, "_mtgt"}, pred_target, e_tgt);
        chk({name, "_mway"}, 32'(pred_way), 32'(e_way));
        @(posedge clk);
        m_apply();
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        @(posedge clk);
        @(posedge clk);
        m_clear();
        #1;
        rst = 0;
    endtask

    initial begin
        idle();
        lk_pc = 0;
        do_reset();

        // Reset state
        look("reset_miss", 32'h100, 0, 32'h104, 0);
        step("reset");

        // Allocate then hit; same-cycle lookup sees old contents
        upd(32'h100, 32'h200, 1);
        look("alloc_same_cycle", 32'h100, 0, 32'h104, 0);
        step("alloc");
        idle();
        look("alloc_hit", 32'h100, 1, 32'h200, 0);
        step("alloc_hit");

        // Retarget without allocation; next allocation in set 0 takes way 1
        upd(32'h100, 32'h300, 1);
        step("retarget");
        idle();
        look("retarget_hit", 32'h100, 1, 32'h300, 0);
        step("retarget_hit");
        upd(32'h040, 32'h340, 1);
        step("alloc_w1");
        idle();
        look("alloc_w1_hit", 32'h040, 1, 32'h340, 1);
        step("alloc_w1_hit");

        // PLRU eviction
        do_reset();
        upd(32'h000, 32'h1000, 1); step("fill0");
        upd(32'h040, 32'h1040, 1); step("fill1");
        upd(32'h080, 32'h1080, 1); step("fill2");
        upd(32'h0C0, 32'h10C0, 1); step("fill3");
        idle();
        lk_valid = 1;
        look("touch0", 32'h000, 1, 32'h1000, 0);
        step("touch0");
        idle();
        upd(32'h100, 32'h500, 1);
        step("evict");
        idle();
        look("evict_new", 32'h100, 1, 32'h500, 2); step("evict_new");
        look("evict_old", 32'h080, 0, 32'h084, 0); step("evict_old");
        look("keep0",     32'h000, 1, 32'h1000, 0); step("keep0");
        look("keep1",     32'h040, 1, 32'h1040, 1); step("keep1");
        look("keep3",     32'h0C0, 1, 32'h10C0, 3); step("keep3");

        // Not-taken update: no allocation, no PLRU change (next victim stays way 1)
        upd(32'h240, 32'h999, 0);
        step("nt");
        idle();
        look("nt_miss", 32'h240, 0, 32'h244, 0); step("nt_miss");
        upd(32'h140, 32'h600, 1);
        step("nt_alloc");
        idle();
        look("nt_victim", 32'h140, 1, 32'h600, 1); step("nt_victim");
        look("nt_evicted", 32'h040, 0, 32'h044, 0); step("nt_evicted");

        // Flush wins over a same-cycle update
        flush = 1;
        upd(32'h380, 32'h400, 1);
        step("flush");
        idle();
        look("flush_upd",  32'h380, 0, 32'h384, 0); step("flush_upd");
        look("flush_old0", 32'h000, 0, 32'h004, 0); step("flush_old0");
        look("flush_old2", 32'h100, 0, 32'h104, 0); step("flush_old2");
        upd(32'h0C0, 32'h777, 1);
        step("post_flush");
        idle();
        look("post_flush_w0", 32'h0C0, 1, 32'h777, 0); step("post_flush_w0");

        // Random traffic over a few sets and tags to force conflicts and evictions
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 299) == 0);
            flush      = ($urandom_range(0, 149) == 0);
            lk_valid   = $urandom_range(0, 1);
            lk_pc      = ($urandom_range(0, 5) << 6) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            upd_valid  = ($urandom_range(0, 2) != 0);
            upd_taken  = ($urandom_range(0, 3) != 0);
            upd_pc     = ($urandom_range(0, 5) << 6) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            upd_target = $urandom;
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
